// File: rtl/tdp_fifo_pkg.sv
// tdp_fifo_pkg
//   Shared sizing constants and pointer helper for the 100-bit x 12-entry
//   FIFO built on the true-dual-port RAM topology.
//   Contents:
//     WIDTH, DEPTH, AW  default data width, entry count, pointer width
//     PTR_LAST          highest valid pointer value (DEPTH-1)
//     ptr_inc()         pointer advance with wrap PTR_LAST -> 0
package tdp_fifo_pkg;

    localparam int WIDTH    = 100;
    localparam int DEPTH    = 12;
    localparam int AW       = 4;
    localparam int PTR_LAST = DEPTH - 1;

    // DEPTH is not a power of two, so the wrap is an explicit compare rather
    // than natural binary rollover.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(PTR_LAST)) ? '0 : ptr + AW'(1);
    endfunction

endpackage

// File: rtl/tdp_fifo_store.sv
// tdp_fifo_store
//   Storage array for the FIFO. Port A writes, port B reads through a
//   registered address with an asynchronous array read. No control logic.
//   Ports:
//     clk         clock
//     wrEn        write strobe for port A
//     wrAddr      port A address
//     wrData      port A write data
//     rdAddrNext  port B address, captured every cycle
//     rdData      contents at the captured port B address
module tdp_fifo_store
    import tdp_fifo_pkg::*;
#(
    parameter int dataWidth = WIDTH,
    parameter int depth     = DEPTH,
    parameter int addrWidth = AW
) (
    input  logic                 clk,
    input  logic                 wrEn,
    input  logic [addrWidth-1:0] wrAddr,
    input  logic [dataWidth-1:0] wrData,
    input  logic [addrWidth-1:0] rdAddrNext,
    output logic [dataWidth-1:0] rdData
);

    logic [dataWidth-1:0] mem [depth];
    logic [addrWidth-1:0] rdAddrQ;

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        rdAddrQ <= rdAddrNext;
    end

    assign rdData = mem[rdAddrQ];

endmodule

// File: rtl/tdp_fifo_100x12.sv
// tdp_fifo_100x12
//   Single-clock 12 x 100-bit valid/ready FIFO. Holds pointers, occupancy,
//   handshake flags and (optionally) sticky error flags around the
//   tdp_fifo_store array.
//   Optional feature macro: TDP_FIFO_ERR_EN adds err_ovf / err_unf.
//   Ports:
//     clk         clock, all logic on posedge
//     rst_n       synchronous active-low reset
//     din         write data
//     din_valid   producer has data
//     din_ready   FIFO can accept (registered)
//     dout        head-of-FIFO data, meaningful while dout_valid=1
//     dout_valid  FIFO non-empty (registered)
//     dout_ready  consumer takes head
//     count       occupancy 0..DEPTH
//     err_ovf     sticky: push attempted while full (TDP_FIFO_ERR_EN only)
//     err_unf     sticky: pop attempted while empty (TDP_FIFO_ERR_EN only)
module tdp_fifo_100x12
    import tdp_fifo_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [AW-1:0]    count
`ifdef TDP_FIFO_ERR_EN
    ,
    output logic             err_ovf,
    output logic             err_unf
`endif
);

    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] rdPtrNext;
    logic [AW-1:0] rdAddrNext;
    logic [AW-1:0] countNext;
    logic          push;
    logic          pop;

    assign push      = din_valid & din_ready;
    assign pop       = dout_valid & dout_ready;
    assign rdPtrNext = pop ? ptr_inc(rdPtr) : rdPtr;

    // The read address register lives in the store and has no reset of its
    // own; forcing zero here lines it up with rdPtr after reset.
    assign rdAddrNext = rst_n ? rdPtrNext : '0;

    always_comb begin
        countNext = count;
        case ({push, pop})
            2'b10:   countNext = count + AW'(1);
            2'b01:   countNext = count - AW'(1);
            default: countNext = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            din_ready  <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= ptr_inc(wrPtr);
            end
            rdPtr      <= rdPtrNext;
            count      <= countNext;
            // Flags follow next-state count so they are exact on the same
            // edge count changes; a pop while full re-opens din_ready only
            // after that edge.
            din_ready  <= (countNext < AW'(DEPTH));
            dout_valid <= (countNext != '0);
        end
    end

    tdp_fifo_store #(
        .dataWidth (WIDTH),
        .depth     (DEPTH),
        .addrWidth (AW)
    ) u_store (
        .clk        (clk),
        .wrEn       (push),
        .wrAddr     (wrPtr),
        .wrData     (din),
        .rdAddrNext (rdAddrNext),
        .rdData     (dout)
    );

`ifdef TDP_FIFO_ERR_EN
    // dout_valid is still low in the first cycle after reset, so a consumer
    // asserting dout_ready then is not an underflow.
    logic firstQ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
            firstQ  <= 1'b1;
        end else begin
            firstQ <= 1'b0;
            if (din_valid && !din_ready && (count == AW'(DEPTH))) begin
                err_ovf <= 1'b1;
            end
            if (dout_ready && !dout_valid && !firstQ) begin
                err_unf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tdp_fifo_100x12.sv
module tb_tdp_fifo_100x12;

    localparam int W = 100;
    localparam int D = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic [3:0]   count;
`ifdef TDP_FIFO_ERR_EN
    logic         err_ovf;
    logic         err_unf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tdp_fifo_100x12 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .count      (count)
`ifdef TDP_FIFO_ERR_EN
        ,
        .err_ovf    (err_ovf),
        .err_unf    (err_unf)
`endif
    );

    // Reference model: plain queue plus the registered ready flag.
    logic [W-1:0] q[$];
    bit           mReady;
    bit           mFirst;
`ifdef TDP_FIFO_ERR_EN
    bit           mOvf;
    bit           mUnf;
`endif

    typedef struct {
        bit           rst;
        bit           dv;
        logic [W-1:0] d;
        bit           dr;
        int           eCount;
        bit           eValid;
        bit           eReady;
        logic [W-1:0] eDout;
        bit           eOvf;
        bit           eUnf;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic cyc(input bit rst, input bit dv, input logic [W-1:0] d, input bit dr);
        bit doPush;
        bit doPop;
        rst_n      = !rst;
        din_valid  = dv;
        din        = d;
        dout_ready = dr;
        if (rst) begin
            q.delete();
            mReady = 1'b0;
            mFirst = 1'b1;
`ifdef TDP_FIFO_ERR_EN
            mOvf = 1'b0;
            mUnf = 1'b0;
`endif
        end else begin
            doPush = dv && mReady;
            doPop  = dr && (q.size() != 0);
`ifdef TDP_FIFO_ERR_EN
            if (dv && !mReady && q.size() == D) mOvf = 1'b1;
            if (dr && q.size() == 0 && !mFirst) mUnf = 1'b1;
`endif
            mFirst = 1'b0;
            if (doPop) void'(q.pop_front());
            if (doPush) q.push_back(d);
            mReady = (q.size() < D);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chkModel(input string name);
        chk({name, ".count"}, count, q.size());
        chk({name, ".valid"}, dout_valid, q.size() != 0);
        chk({name, ".ready"}, din_ready, mReady);
        if (q.size() != 0) chk({name, ".dout"}, dout, q[0]);
`ifdef TDP_FIFO_ERR_EN
        chk({name, ".ovf"}, err_ovf, mOvf);
        chk({name, ".unf"}, err_unf, mUnf);
`endif
    endtask

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;

        //          rst dv d  dr  cnt val rdy dout ovf unf
        tbl[0]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0,  0, 0, 1, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0,  1, 1, 1, 1, 0, 0};
        tbl[3]  = '{0, 1, 2, 0,  2, 1, 1, 1, 0, 0};
        tbl[4]  = '{0, 1, 3, 0,  3, 1, 1, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 1,  2, 1, 1, 2, 0, 0};
        tbl[6]  = '{0, 1, 4, 1,  2, 1, 1, 3, 0, 0};
        tbl[7]  = '{0, 0, 0, 1,  1, 1, 1, 4, 0, 0};
        tbl[8]  = '{0, 0, 0, 1,  0, 0, 1, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 1,  0, 0, 1, 0, 0, 1};
        tbl[10] = '{0, 1, 5, 1,  1, 1, 1, 5, 0, 1};

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].rst, tbl[i].dv, tbl[i].d, tbl[i].dr);
            chk($sformatf("vec%0d.count", i), count, tbl[i].eCount);
            chk($sformatf("vec%0d.valid", i), dout_valid, tbl[i].eValid);
            chk($sformatf("vec%0d.ready", i), din_ready, tbl[i].eReady);
            if (tbl[i].eValid) chk($sformatf("vec%0d.dout", i), dout, tbl[i].eDout);
`ifdef TDP_FIFO_ERR_EN
            chk($sformatf("vec%0d.ovf", i), err_ovf, tbl[i].eOvf);
            chk($sformatf("vec%0d.unf", i), err_unf, tbl[i].eUnf);
`endif
        end

        // Fill to full, then a refused 13th push.
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < D; i++) cyc(0, 1, W'('h100 + i), 0);
        chk("full.count", count, 12);
        chk("full.ready", din_ready, 0);
        cyc(0, 1, W'('h1FF), 0);
        chk("refuse.count", count, 12);
        chk("refuse.dout", dout, W'('h100));
`ifdef TDP_FIFO_ERR_EN
        chk("refuse.ovf", err_ovf, 1);
`endif
        chkModel("refuse");

        // Full with push and pop together: pop only.
        cyc(0, 1, W'('h2AA), 1);
        chk("fullpop.count", count, 11);
        chk("fullpop.ready", din_ready, 1);
        chk("fullpop.dout", dout, W'('h101));
        cyc(0, 1, W'('h2AB), 0);
        chk("refill.count", count, 12);
        chkModel("refill");
        for (int i = 0; i < D; i++) begin
            cyc(0, 0, 0, 1);
            chkModel($sformatf("drain%0d", i));
        end

        // Streaming at occupancy 2 across two pointer wraps.
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, W'('h300), 0);
        cyc(0, 1, W'('h301), 0);
        for (int i = 0; i < 30; i++) begin
            cyc(0, 1, W'('h400 + i), 1);
            chk($sformatf("stream%0d.count", i), count, 2);
            chk($sformatf("stream%0d.dout", i), dout,
                (i == 0) ? W'('h301) : W'('h400 + i - 1));
        end

        // Drain and pop an empty FIFO.
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("empty.count", count, 0);
        chk("empty.valid", dout_valid, 0);
`ifdef TDP_FIFO_ERR_EN
        chk("empty.unf", err_unf, 1);
`endif
        chkModel("empty");

        // Reset mid-operation at count 7.
        for (int i = 0; i < 7; i++) cyc(0, 1, W'('h500 + i), 0);
        chk("pre_rst.count", count, 7);
        cyc(1, 0, 0, 0);
        chk("midrst.count", count, 0);
        chk("midrst.valid", dout_valid, 0);
        chk("midrst.ready", din_ready, 0);
        cyc(0, 0, 0, 0);
        chk("postrst.ready", din_ready, 1);
        cyc(0, 1, W'('hABC), 0);
        chk("abc.valid", dout_valid, 1);
        chk("abc.dout", dout, W'('hABC));
        chk("abc.count", count, 1);
        chkModel("abc");

        // Randomized traffic with alternating fill/drain bias.
        for (int i = 0; i < 800; i++) begin
            bit rst;
            bit dv;
            bit dr;
            logic [127:0] r;
            rst = ($urandom_range(149) == 0);
            if ((i % 200) < 100) begin
                dv = ($urandom_range(3) != 0);
                dr = ($urandom_range(3) == 0);
            end else begin
                dv = ($urandom_range(3) == 0);
                dr = ($urandom_range(3) != 0);
            end
            r = {$urandom, $urandom, $urandom, $urandom};
            cyc(rst, dv, r[W-1:0], dr);
            chkModel($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
